// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared widths, FSM encoding and writeback source codes for the memory stage
package mem_wb_pkg;

    localparam int OPERAND_WIDTH  = 16;
    localparam int WAIT_CNT_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    localparam logic [1:0] DTR_ALU = 2'd0;
    localparam logic [1:0] DTR_MEM = 2'd1;
    localparam logic [1:0] DTR_PC  = 2'd2;

endpackage

// File: rtl/mem_ctl_fsm.sv
// rtl/mem_ctl_fsm.sv - data-memory request sequencer with wait counter and timeout abort
module mem_ctl_fsm
    import mem_wb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    input  logic mem_done,
    output logic mem_rd,
    output logic mem_wr,
    output logic stall,
    output logic complete,
    output logic timeout
);

    mem_state_e                state;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic                      req;

    assign req = mem_read | mem_write;

    // Strobes and stall are combinational so a same-cycle mem_done costs no stall.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    mem_wr   = mem_write;
                    mem_rd   = mem_read & ~mem_write;
                    stall    = req & ~mem_done;
                    complete = req & mem_done;
                end
                BUSY: begin
                    timeout  = ~mem_done && (wait_cnt == WAIT_CNT_WIDTH'(TIMEOUT - 1));
                    stall    = ~mem_done & ~timeout;
                    complete = mem_done | timeout;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (req && !mem_done) state <= BUSY;
                end
                BUSY: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mem_done || timeout) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - memory stage: issues data-memory accesses and holds the MEM/WB pipeline registers
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int OPERAND_WIDTH = mem_wb_pkg::OPERAND_WIDTH,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPERAND_WIDTH-1:0] ex_mem_read2Data,
    input  logic [OPERAND_WIDTH-1:0] ex_mem_AluRes,
    input  logic [OPERAND_WIDTH-1:0] ex_mem_PC_incr,
    input  logic [1:0]               ex_mem_DatatoReg,
    input  logic [2:0]               ex_mem_writeRegSel,
    input  logic                     ex_mem_MemRead,
    input  logic                     ex_mem_MemWrite,
    input  logic                     ex_mem_RegWrite,
    input  logic                     ex_mem_Halt,
    output logic [OPERAND_WIDTH-1:0] mem_Addr,
    output logic [OPERAND_WIDTH-1:0] mem_DataIn,
    output logic                     mem_Rd,
    output logic                     mem_Wr,
    input  logic [OPERAND_WIDTH-1:0] mem_DataOut,
    input  logic                     mem_Done,
    input  logic                     mem_Err,
    output logic                     DMemStall,
    output logic [OPERAND_WIDTH-1:0] mem_wb_ReadData,
    output logic [OPERAND_WIDTH-1:0] mem_wb_AluRes,
    output logic [OPERAND_WIDTH-1:0] mem_wb_PC_incr,
    output logic [1:0]               mem_wb_DatatoReg,
    output logic [2:0]               mem_wb_writeRegSel,
    output logic                     mem_wb_RegWrite,
    output logic                     mem_wb_Halt,
    output logic                     mem_wb_Err
);

    logic complete;
    logic timeout;
    logic mem_op;
    logic rd_done;

    assign mem_Addr   = ex_mem_AluRes;
    assign mem_DataIn = ex_mem_read2Data;
    assign mem_op     = ex_mem_MemRead | ex_mem_MemWrite;
    // ex_mem is frozen by the stall, so its controls still describe the access in flight.
    assign rd_done    = complete & ex_mem_MemRead & ~ex_mem_MemWrite & ~timeout;

    mem_ctl_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (ex_mem_MemRead),
        .mem_write (ex_mem_MemWrite),
        .mem_done  (mem_Done),
        .mem_rd    (mem_Rd),
        .mem_wr    (mem_Wr),
        .stall     (DMemStall),
        .complete  (complete),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_ReadData    <= '0;
            mem_wb_AluRes      <= '0;
            mem_wb_PC_incr     <= '0;
            mem_wb_DatatoReg   <= '0;
            mem_wb_writeRegSel <= '0;
            mem_wb_RegWrite    <= 1'b0;
            mem_wb_Halt        <= 1'b0;
            mem_wb_Err         <= 1'b0;
        end else if (!mem_wb_Halt) begin
            if (DMemStall) begin
                mem_wb_RegWrite <= 1'b0;
                mem_wb_Halt     <= 1'b0;
            end else begin
                mem_wb_ReadData    <= rd_done ? mem_DataOut : '0;
                mem_wb_AluRes      <= ex_mem_AluRes;
                mem_wb_PC_incr     <= ex_mem_PC_incr;
                mem_wb_DatatoReg   <= ex_mem_DatatoReg;
                mem_wb_writeRegSel <= ex_mem_writeRegSel;
                mem_wb_RegWrite    <= ex_mem_RegWrite;
                mem_wb_Halt        <= ex_mem_Halt;
                mem_wb_Err         <= timeout | (mem_Err & mem_Done & mem_op);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - scoreboard bench for the memory/writeback stage
module tb_mem_wb;
    import mem_wb_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] rdata;
        logic [W-1:0] alu;
        logic [W-1:0] pc;
        logic [1:0]   dtr;
        logic [2:0]   sel;
        logic         rw;
        logic         halt;
        logic         err;
    } wb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] ex_mem_read2Data = '0, ex_mem_AluRes = '0, ex_mem_PC_incr = '0;
    logic [1:0]   ex_mem_DatatoReg = '0;
    logic [2:0]   ex_mem_writeRegSel = '0;
    logic         ex_mem_MemRead = 1'b0, ex_mem_MemWrite = 1'b0, ex_mem_RegWrite = 1'b0, ex_mem_Halt = 1'b0;
    logic [W-1:0] mem_Addr, mem_DataIn, mem_DataOut = '0;
    logic         mem_Rd, mem_Wr, mem_Done = 1'b0, mem_Err = 1'b0, DMemStall;
    logic [W-1:0] mem_wb_ReadData, mem_wb_AluRes, mem_wb_PC_incr;
    logic [1:0]   mem_wb_DatatoReg;
    logic [2:0]   mem_wb_writeRegSel;
    logic         mem_wb_RegWrite, mem_wb_Halt, mem_wb_Err;

    int  n_vec = 0;
    int  n_err = 0;
    wb_t sb[$];

    always #5 clk = ~clk;

    mem_wb #(.OPERAND_WIDTH(W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_read2Data(ex_mem_read2Data), .ex_mem_AluRes(ex_mem_AluRes), .ex_mem_PC_incr(ex_mem_PC_incr),
        .ex_mem_DatatoReg(ex_mem_DatatoReg), .ex_mem_writeRegSel(ex_mem_writeRegSel),
        .ex_mem_MemRead(ex_mem_MemRead), .ex_mem_MemWrite(ex_mem_MemWrite),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_Halt(ex_mem_Halt),
        .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Err(mem_Err), .DMemStall(DMemStall),
        .mem_wb_ReadData(mem_wb_ReadData), .mem_wb_AluRes(mem_wb_AluRes), .mem_wb_PC_incr(mem_wb_PC_incr),
        .mem_wb_DatatoReg(mem_wb_DatatoReg), .mem_wb_writeRegSel(mem_wb_writeRegSel),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_Halt(mem_wb_Halt), .mem_wb_Err(mem_wb_Err)
    );

    function automatic wb_t observed();
        wb_t o;
        o.rdata = mem_wb_ReadData;
        o.alu   = mem_wb_AluRes;
        o.pc    = mem_wb_PC_incr;
        o.dtr   = mem_wb_DatatoReg;
        o.sel   = mem_wb_writeRegSel;
        o.rw    = mem_wb_RegWrite;
        o.halt  = mem_wb_Halt;
        o.err   = mem_wb_Err;
        return o;
    endfunction

    // One instruction through the stage; done_dly < 0 means the memory never answers.
    task automatic run_op(input string name, input logic rd, input logic wr, input logic rw, input logic hlt,
                          input logic [W-1:0] alu, input logic [W-1:0] wdata, input logic [W-1:0] pc,
                          input logic [1:0] dtr, input logic [2:0] sel, input int done_dly,
                          input logic [W-1:0] dout, input logic err, input int exp_stalls);
        wb_t e, o;
        int  cyc, stalls, rdp, wrp;
        bit  fin, st;
        logic mem;
        mem = rd | wr;
        @(negedge clk);
        ex_mem_MemRead = rd; ex_mem_MemWrite = wr; ex_mem_RegWrite = rw; ex_mem_Halt = hlt;
        ex_mem_AluRes = alu; ex_mem_read2Data = wdata; ex_mem_PC_incr = pc;
        ex_mem_DatatoReg = dtr; ex_mem_writeRegSel = sel;
        e.rdata = (rd && !wr && done_dly >= 0) ? dout : '0;
        e.alu = alu; e.pc = pc; e.dtr = dtr; e.sel = sel; e.rw = rw; e.halt = hlt;
        e.err = (mem && done_dly < 0) || (err && mem && done_dly >= 0);
        sb.push_back(e);
        cyc = 0; stalls = 0; rdp = 0; wrp = 0; fin = 0;
        while (!fin) begin
            mem_Done    = (cyc == done_dly);
            mem_Err     = err && (cyc == done_dly);
            mem_DataOut = (cyc == done_dly) ? dout : W'($urandom);
            #1;
            if (mem_Rd) rdp++;
            if (mem_Wr) wrp++;
            if (cyc == 0) begin
                n_vec++;
                if (mem_Addr !== alu || mem_DataIn !== wdata) begin
                    n_err++;
                    $display("FAIL %s addr/datain: got %h/%h want %h/%h", name, mem_Addr, mem_DataIn, alu, wdata);
                end
            end
            st = DMemStall;
            @(posedge clk); #1;
            if (st) begin
                stalls++;
                n_vec++;
                if (mem_wb_RegWrite !== 1'b0 || mem_wb_Halt !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s bubble: regwrite=%b halt=%b want 0/0", name, mem_wb_RegWrite, mem_wb_Halt);
                end
            end else begin
                e = sb.pop_front();
                o = observed();
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL %s writeback: got %h want %h", name, o, e);
                end
                fin = 1;
            end
            cyc++;
            if (!fin) begin
                if (cyc > 100) begin
                    n_err++;
                    $display("FAIL %s no completion: stalls=%0d", name, stalls);
                    void'(sb.pop_front());
                    fin = 1;
                end else @(negedge clk);
            end
        end
        mem_Done = 1'b0; mem_Err = 1'b0;
        n_vec++;
        if (stalls != exp_stalls) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, exp_stalls);
        end
        n_vec++;
        if (rdp != int'(rd & ~wr) || wrp != int'(wr)) begin
            n_err++;
            $display("FAIL %s strobes: rd=%0d wr=%0d want %0d/%0d", name, rdp, wrp, rd & ~wr, wr);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_vec++;
        if (observed() !== '0 || mem_Rd !== 1'b0 || mem_Wr !== 1'b0 || DMemStall !== 1'b0) begin
            n_err++;
            $display("FAIL %s: wb=%h rd=%b wr=%b stall=%b want all 0", name, observed(), mem_Rd, mem_Wr, DMemStall);
        end
    endtask

    task automatic test_reset();
        ex_mem_MemRead = 1'b1; ex_mem_MemWrite = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset");
        @(negedge clk);
        ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_load_hit();
        run_op("load_hit", 1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0102, DTR_MEM, 3'd2, 0, 16'hBEEF, 0, 0);
    endtask

    task automatic test_store_wait();
        run_op("store_wait", 0, 1, 0, 0, 16'h0010, 16'h1234, 16'h0104, DTR_ALU, 3'd0, 3, 16'h0000, 0, 3);
    endtask

    task automatic test_rw_priority();
        run_op("rw_priority", 1, 1, 0, 0, 16'h0020, 16'h5A5A, 16'h0106, DTR_MEM, 3'd1, 1, 16'h7777, 0, 1);
    endtask

    task automatic test_mem_err();
        run_op("mem_err", 1, 0, 1, 0, 16'h0030, 16'h0000, 16'h0108, DTR_MEM, 3'd4, 2, 16'hC0DE, 1, 2);
    endtask

    task automatic test_idle_ignore();
        run_op("idle_ignore", 0, 0, 1, 0, 16'h0055, 16'h0000, 16'h010A, DTR_ALU, 3'd5, 0, 16'hDEAD, 1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_op("back_to_back", i[0], ~i[0], i[0], 0, W'(16'h0200 + i), W'($urandom), W'(16'h0300 + 2 * i),
                   DTR_MEM, 3'(i), i, W'($urandom), 0, i);
    endtask

    task automatic test_timeout();
        run_op("timeout", 1, 0, 1, 0, 16'h0070, 16'h0000, 16'h010C, DTR_MEM, 3'd6, -1, 16'h0000, 0, 8);
    endtask

    task automatic test_alu_halt();
        wb_t held;
        run_op("alu_r3", 0, 0, 1, 0, 16'h0007, 16'h0000, 16'h010E, DTR_ALU, 3'd3, 0, 16'h0000, 0, 0);
        run_op("halt", 0, 0, 0, 1, 16'h0099, 16'h0000, 16'h0110, DTR_PC, 3'd0, 0, 16'h0000, 0, 0);
        held = observed();
        @(negedge clk);
        ex_mem_Halt = 1'b0; ex_mem_RegWrite = 1'b1; ex_mem_AluRes = 16'hFFFF;
        ex_mem_PC_incr = 16'hAAAA; ex_mem_writeRegSel = 3'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (observed() !== held || mem_wb_Halt !== 1'b1) begin
                n_err++;
                $display("FAIL halt_hold: got %h want %h", observed(), held);
            end
        end
    endtask

    task automatic test_reset_in_busy();
        @(negedge clk);
        ex_mem_MemRead = 1'b1; ex_mem_MemWrite = 1'b0; ex_mem_RegWrite = 1'b1;
        ex_mem_AluRes = 16'h0080; mem_Done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (DMemStall !== 1'b1) begin
            n_err++;
            $display("FAIL busy_before_reset: stall=%b want 1", DMemStall);
        end
        #1;
        rst = 1'b0;
        ex_mem_MemRead = 1'b0; ex_mem_RegWrite = 1'b0;
        #1;
        check_all_zero("reset_in_busy");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (mem_Rd !== 1'b0 || DMemStall !== 1'b0 || mem_wb_RegWrite !== 1'b0) begin
                n_err++;
                $display("FAIL after_reset: rd=%b stall=%b regwrite=%b want 0/0/0", mem_Rd, DMemStall, mem_wb_RegWrite);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_store_wait();
        test_rw_priority();
        test_mem_err();
        test_idle_ignore();
        test_back_to_back();
        test_timeout();
        test_alu_halt();
        test_reset_in_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
